// File: rtl/fifo_route_pkg.sv
// Shared constants, symbol type and width helper for the FIFO route/demux path.
package fifo_route_pkg;

  localparam int unsigned FR_DATA_W = 4;
  localparam int unsigned FR_DEPTH  = 16;
  localparam int unsigned FR_NUM_CH = 4;

  // One buffered symbol at the default width (a Zigbee nibble).
  typedef logic [FR_DATA_W-1:0] fr_symbol_t;

  // $clog2 with a floor of 1 so that derived vector widths are never zero.
  function automatic int unsigned fr_clog2(input int unsigned value);
    int unsigned width;
    width = int'($clog2(value));
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/fifo_route_mem.sv
// Synchronous FIFO storage: array, wrapping pointers, occupancy level, full/empty
// and a sticky overflow flag. The storage array is deliberately not reset.
module fifo_route_mem
  import fifo_route_pkg::*;
#(
  parameter int unsigned DataW = FR_DATA_W,
  parameter int unsigned Depth = FR_DEPTH,
  parameter int unsigned LvlW  = fr_clog2(FR_DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic             pop_i,
  output logic [DataW-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LvlW-1:0]  level_o,
  output logic             overflow_o
);

  localparam int unsigned PtrW = fr_clog2(Depth);

  logic [DataW-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             overflow_q, overflow_d;
  logic             wr_fire, rd_fire;

  assign full_o     = (level_q == LvlW'(Depth));
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;
  assign overflow_o = overflow_q;
  assign rdata_o    = mem_q[rd_ptr_q];

  // A write while full is refused even if a pop frees a slot in the same cycle.
  assign wr_fire = wr_en_i & ~full_o;
  assign rd_fire = pop_i & ~empty_o;

  // Next-state for pointers, level and overflow; pointers wrap naturally (Depth is 2^n).
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_en_i && full_o) overflow_d = 1'b1;
    case ({wr_fire, rd_fire})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage write port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fifo_route_demux.sv
// FIFO + demux: buffers symbols and dispatches each popped symbol to the channel
// named by the active-select register, into a per-channel valid/ready holding stage.
// Optional build macro FIFO_ROUTE_RR_EN adds inRoundRobin (select auto-advance).
module fifo_route_demux
  import fifo_route_pkg::*;
#(
  parameter int unsigned DATA_W = FR_DATA_W,
  parameter int unsigned DEPTH  = FR_DEPTH,
  parameter int unsigned NUM_CH = FR_NUM_CH,
  parameter int unsigned SEL_W  = fr_clog2(NUM_CH),
  parameter int unsigned LVL_W  = fr_clog2(DEPTH + 1)
) (
  input  logic                     inClock,
  input  logic                     inReset,
  input  logic [DATA_W-1:0]        inData,
  input  logic                     inWriteEnable,
  output logic                     outFull,
  output logic                     outEmpty,
  output logic [LVL_W-1:0]         outLevel,
  output logic                     outOverflow,
  input  logic [SEL_W-1:0]         inSel,
  input  logic                     inSelLoad,
`ifdef FIFO_ROUTE_RR_EN
  input  logic                     inRoundRobin,
`endif
  output logic                     outSelError,
  input  logic [NUM_CH-1:0]        inReadEnable,
  output logic [NUM_CH-1:0]        outValid,
  output logic [NUM_CH*DATA_W-1:0] outData
);

  logic [DATA_W-1:0]             head;
  logic                          fifo_empty;
  logic                          pop;
  logic                          sel_error;
  logic [SEL_W-1:0]              sel_q, sel_d;
  logic [NUM_CH-1:0]             sel_oh;
  logic [NUM_CH-1:0]             load_oh;
  logic [NUM_CH-1:0]             valid_q, valid_d;
  logic [NUM_CH-1:0][DATA_W-1:0] data_q, data_d;

  fifo_route_mem #(
    .DataW (DATA_W),
    .Depth (DEPTH),
    .LvlW  (LVL_W)
  ) u_mem (
    .clk_i      (inClock),
    .rst_ni     (inReset),
    .wr_en_i    (inWriteEnable),
    .wdata_i    (inData),
    .pop_i      (pop),
    .rdata_o    (head),
    .full_o     (outFull),
    .empty_o    (fifo_empty),
    .level_o    (outLevel),
    .overflow_o (outOverflow)
  );

  // Out-of-range select only exists when NUM_CH is not a power of two.
  if ((1 << SEL_W) > NUM_CH) begin : g_sel_range
    localparam logic [SEL_W-1:0] NumChSel = SEL_W'(NUM_CH);
    assign sel_error = (sel_q >= NumChSel);
  end else begin : g_sel_full
    assign sel_error = 1'b0;
  end

  // An out-of-range select shifts the one-hot to zero, so it can never load a channel.
  assign sel_oh  = NUM_CH'(1'b1) << sel_q;
  assign pop     = ~fifo_empty & ~sel_error & (|(sel_oh & (~valid_q | inReadEnable)));
  assign load_oh = pop ? sel_oh : '0;

  assign outEmpty    = fifo_empty;
  assign outSelError = sel_error;
  assign outValid    = valid_q;
  assign outData     = data_q;

`ifdef FIFO_ROUTE_RR_EN
  localparam logic [SEL_W-1:0] SelLast = SEL_W'(NUM_CH - 1);
`endif

  // Active select: explicit load wins; optional round-robin advance after each pop.
  always_comb begin
    sel_d = sel_q;
    if (inSelLoad) begin
      sel_d = inSel;
    end
`ifdef FIFO_ROUTE_RR_EN
    else if (inRoundRobin && pop) begin
      sel_d = (sel_q == SelLast) ? '0 : sel_q + 1'b1;
    end
`endif
  end

  // Holding stages: a load takes priority over a consume in the same cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (load_oh[c]) begin
        valid_d[c] = 1'b1;
        data_d[c]  = head;
      end else if (inReadEnable[c]) begin
        valid_d[c] = 1'b0;
      end
    end
  end

  // Select and holding-stage registers.
  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      sel_q   <= '0;
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      sel_q   <= sel_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_fifo_route_demux.sv
// Self-checking bench for fifo_route_demux: directed vector table, hand sequences for
// stall / select / parked-select / reset corners, and a queue-based random reference.
// Build with FIFO_ROUTE_RR_EN defined to also exercise round-robin dispatch.
module tb_fifo_route_demux;
  import fifo_route_pkg::*;

  localparam int unsigned DW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned NCH   = 4;
  localparam int unsigned NCH3  = 3;
  localparam int unsigned LW    = 5;
  localparam int unsigned SW    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (NUM_CH = 4)
  logic              wr, sel_load;
  logic [DW-1:0]     wdata;
  logic [SW-1:0]     sel;
  logic [NCH-1:0]    rd;
  logic              full, empty, ovf, sel_err;
  logic [LW-1:0]     level;
  logic [NCH-1:0]    valid;
  logic [NCH*DW-1:0] odata;
`ifdef FIFO_ROUTE_RR_EN
  logic              rr;
`endif

  // Second DUT (NUM_CH = 3) for out-of-range select
  logic               wr3, sel_load3;
  logic [DW-1:0]      wdata3;
  logic [SW-1:0]      sel3;
  logic [NCH3-1:0]    rd3;
  logic               full3, empty3, ovf3, sel_err3;
  logic [LW-1:0]      level3;
  logic [NCH3-1:0]    valid3;
  logic [NCH3*DW-1:0] odata3;

  fifo_route_demux #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_CH(NCH)) dut (
    .inClock       (clk),
    .inReset       (rst_n),
    .inData        (wdata),
    .inWriteEnable (wr),
    .outFull       (full),
    .outEmpty      (empty),
    .outLevel      (level),
    .outOverflow   (ovf),
    .inSel         (sel),
    .inSelLoad     (sel_load),
`ifdef FIFO_ROUTE_RR_EN
    .inRoundRobin  (rr),
`endif
    .outSelError   (sel_err),
    .inReadEnable  (rd),
    .outValid      (valid),
    .outData       (odata)
  );

  fifo_route_demux #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_CH(NCH3)) dut3 (
    .inClock       (clk),
    .inReset       (rst_n),
    .inData        (wdata3),
    .inWriteEnable (wr3),
    .outFull       (full3),
    .outEmpty      (empty3),
    .outLevel      (level3),
    .outOverflow   (ovf3),
    .inSel         (sel3),
    .inSelLoad     (sel_load3),
`ifdef FIFO_ROUTE_RR_EN
    .inRoundRobin  (1'b0),
`endif
    .outSelError   (sel_err3),
    .inReadEnable  (rd3),
    .outValid      (valid3),
    .outData       (odata3)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: symbol queue plus per-channel hold state.
  fr_symbol_t   m_q[$];
  int           m_sel;
  logic [NCH-1:0] m_valid;
  logic [DW-1:0]  m_data[NCH];
  logic           m_ovf;

  task automatic model_clear();
    m_q.delete();
    m_sel   = 0;
    m_valid = '0;
    m_ovf   = 1'b0;
    for (int c = 0; c < NCH; c++) m_data[c] = '0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int qs;
    bit do_pop;
    qs = m_q.size();
    if (wr && qs == DEPTH) m_ovf = 1'b1;
    do_pop = (qs > 0) && (m_sel < NCH) && (!m_valid[m_sel] || rd[m_sel]);
    for (int c = 0; c < NCH; c++) begin
      if (do_pop && c == m_sel) begin
        m_valid[c] = 1'b1;
        m_data[c]  = m_q[0];
      end else if (m_valid[c] && rd[c]) begin
        m_valid[c] = 1'b0;
      end
    end
    if (do_pop) void'(m_q.pop_front());
    if (wr && qs < DEPTH) m_q.push_back(wdata);
    if (sel_load) m_sel = int'(sel);
  endtask

  task automatic do_reset();
    wr = 1'b0; wdata = '0; sel_load = 1'b0; sel = '0; rd = '0;
    wr3 = 1'b0; wdata3 = '0; sel_load3 = 1'b0; sel3 = '0; rd3 = '0;
`ifdef FIFO_ROUTE_RR_EN
    rr = 1'b0;
`endif
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  typedef struct {
    logic           wr;
    logic [DW-1:0]  data;
    logic [NCH-1:0] rdy;
    logic [NCH-1:0] exp_valid;
    logic [LW-1:0]  exp_level;
    logic [DW-1:0]  exp_d0;
  } vec_t;

  vec_t vecs[5];
  logic [DW-1:0]     syms[20];
  logic [NCH*DW-1:0] exp_data;
  int                exp_ch;

  initial begin
    #400000;
    $display("FAIL timeout reached actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // ---- Reset state
    do_reset();
    check("rst_level", 64'(level), 64'(0));
    check("rst_empty", 64'(empty), 64'(1));
    check("rst_full", 64'(full), 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));
    check("rst_valid", 64'(valid), 64'(0));
    check("rst_data", 64'(odata), 64'(0));
    check("rst_selerr", 64'(sel_err), 64'(0));
    check("rst_selerr3", 64'(sel_err3), 64'(0));

    // ---- Table: D,3,7 through channel 0
    vecs[0] = '{1'b1, 4'hD, 4'b0001, 4'b0000, 5'd1, 4'h0};
    vecs[1] = '{1'b1, 4'h3, 4'b0001, 4'b0001, 5'd1, 4'hD};
    vecs[2] = '{1'b1, 4'h7, 4'b0001, 4'b0001, 5'd1, 4'h3};
    vecs[3] = '{1'b0, 4'h0, 4'b0001, 4'b0001, 5'd0, 4'h7};
    vecs[4] = '{1'b0, 4'h0, 4'b0001, 4'b0000, 5'd0, 4'h7};
    for (int i = 0; i < 5; i++) begin
      wr = vecs[i].wr; wdata = vecs[i].data; rd = vecs[i].rdy; sel = '0;
      tick();
      check($sformatf("tbl%0d_valid", i), 64'(valid), 64'(vecs[i].exp_valid));
      check($sformatf("tbl%0d_level", i), 64'(level), 64'(vecs[i].exp_level));
      check($sformatf("tbl%0d_d0", i), 64'(odata[DW-1:0]), 64'(vecs[i].exp_d0));
    end

    // ---- Fill with channel 0 holding one symbol: 17 accepted writes to reach full
    do_reset();
    for (int i = 0; i < 18; i++) syms[i] = DW'(i * 3 + 1);
    for (int i = 0; i < 17; i++) begin
      wr = 1'b1; wdata = syms[i];
      tick();
      if (i == 15) check("fill_notfull16", 64'(full), 64'(0));
    end
    check("fill_full", 64'(full), 64'(1));
    check("fill_level", 64'(level), 64'(16));
    check("fill_noovf", 64'(ovf), 64'(0));
    check("fill_hold0", 64'(odata[DW-1:0]), 64'(syms[0]));
    wdata = syms[17];
    tick();
    check("ovf_set", 64'(ovf), 64'(1));
    check("ovf_level", 64'(level), 64'(16));
    wr = 1'b0;
    tick();
    check("ovf_sticky", 64'(ovf), 64'(1));

    // ---- Channel 2 stall then single release
    do_reset();
    sel_load = 1'b1; sel = 2'd2; wr = 1'b1; wdata = 4'hA;
    tick();
    sel_load = 1'b0; wdata = 4'hB;
    tick();
    wdata = 4'hC;
    tick();
    wr = 1'b0;
    tick();
    check("stall_level", 64'(level), 64'(2));
    check("stall_valid", 64'(valid), 64'(4'b0100));
    check("stall_d2", 64'(odata[2*DW +: DW]), 64'(4'hA));
    rd = 4'b0100;
    tick();
    rd = 4'b0000;
    check("rel_level", 64'(level), 64'(1));
    check("rel_valid", 64'(valid), 64'(4'b0100));
    check("rel_d2", 64'(odata[2*DW +: DW]), 64'(4'hB));
    tick();
    check("rel_level_hold", 64'(level), 64'(1));

    // ---- Select load in the same cycle as a pop
    do_reset();
    rd = 4'b1111; wr = 1'b1; wdata = 4'h5;
    tick();
    wdata = 4'h9; sel_load = 1'b1; sel = 2'd1;
    tick();
    check("selpop_valid", 64'(valid), 64'(4'b0001));
    check("selpop_d0", 64'(odata[DW-1:0]), 64'(4'h5));
    wr = 1'b0; sel_load = 1'b0;
    tick();
    check("selnext_valid", 64'(valid), 64'(4'b0010));
    check("selnext_d1", 64'(odata[DW +: DW]), 64'(4'h9));

    // ---- NUM_CH=3: parked select out of range, fill, then resume in order
    do_reset();
    rd3 = 3'b111; sel_load3 = 1'b1; sel3 = 2'd3;
    tick();
    sel_load3 = 1'b0;
    check("sel3_err", 64'(sel_err3), 64'(1));
    for (int i = 0; i < 17; i++) syms[i] = DW'(i * 7 + 3);
    for (int i = 0; i < 16; i++) begin
      wr3 = 1'b1; wdata3 = syms[i];
      tick();
    end
    check("sel3_full", 64'(full3), 64'(1));
    check("sel3_level", 64'(level3), 64'(16));
    check("sel3_novalid", 64'(valid3), 64'(0));
    wdata3 = 4'hF;
    tick();
    check("sel3_ovf", 64'(ovf3), 64'(1));
    check("sel3_ovf_level", 64'(level3), 64'(16));
    wr3 = 1'b0; sel_load3 = 1'b1; sel3 = 2'd0;
    tick();
    sel_load3 = 1'b0;
    check("sel3_clear", 64'(sel_err3), 64'(0));
    check("sel3_nopop_yet", 64'(level3), 64'(16));
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("sel3_order%0d", i), 64'(odata3[DW-1:0]), 64'(syms[i]));
      check($sformatf("sel3_lvl%0d", i), 64'(level3), 64'(15 - i));
    end
    check("sel3_valid_last", 64'(valid3), 64'(3'b001));

    // ---- Randomised run against the queue model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      wr       = ($urandom_range(0, 99) < 65);
      wdata    = DW'($urandom);
      rd       = (n < 200) ? NCH'($urandom & $urandom & $urandom) : NCH'($urandom);
      sel_load = ($urandom_range(0, 7) == 0);
      sel      = SW'($urandom);
      model_step();
      tick();
      for (int c = 0; c < NCH; c++) exp_data[c*DW +: DW] = m_data[c];
      check("rnd_level", 64'(level), 64'(m_q.size()));
      check("rnd_flags", 64'({full, empty, ovf, sel_err}),
            64'({m_q.size() == DEPTH, m_q.size() == 0, m_ovf, 1'b0}));
      check("rnd_valid", 64'(valid), 64'(m_valid));
      check("rnd_data", 64'(odata), 64'(exp_data));
    end

    // ---- Streaming dispatch (round-robin when enabled), then reset mid-stream
    do_reset();
    rd = 4'b1111; sel = '0;
`ifdef FIFO_ROUTE_RR_EN
    rr = 1'b1;
`endif
    for (int i = 0; i < 10; i++) syms[i] = DW'(i * 5 + 2);
    for (int i = 0; i < 10; i++) begin
      wr = 1'b1; wdata = syms[i];
      tick();
      if (i >= 1) begin
`ifdef FIFO_ROUTE_RR_EN
        exp_ch = (i - 1) % NCH;
`else
        exp_ch = 0;
`endif
        check($sformatf("stream_valid%0d", i), 64'(valid), 64'(1 << exp_ch));
        check($sformatf("stream_data%0d", i), 64'(odata[exp_ch*DW +: DW]), 64'(syms[i-1]));
      end
    end
    check("stream_level", 64'(level), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(valid), 64'(0));
    check("midrst_level", 64'(level), 64'(0));
    check("midrst_empty", 64'(empty), 64'(1));
    wr = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("postrst_valid", 64'(valid), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
